// File: rtl/line_mem_pkg.sv
// Shared constants and FSM state type for the line-wide memory responder.
// Optional build macro LINE_MEM_STATS_EN is consumed by line_mem_responder.
package line_mem_pkg;

  localparam int LINE_W      = 256;
  localparam int OFF         = $clog2(LINE_W / 8);
  localparam int DEPTH_DEF   = 512;
  localparam int LATENCY_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

endpackage

// File: rtl/line_mem_array.sv
// Single-port DEPTH x LINE_W line storage: synchronous write, registered read
// (the read register is cleared by reset, the storage itself is not).
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int  LINE_W_P = LINE_W,
  parameter int  DEPTH    = DEPTH_DEF,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_W-1:0]    idx,
  input  logic [LINE_W_P-1:0] wdata,
  output logic [LINE_W_P-1:0] rdata
);

  logic [LINE_W_P-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset branch; clearing it would turn a RAM
  // into a flop array. Only the read register below is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the dcache line interface with fixed access latency.
// Define LINE_MEM_STATS_EN to add saturating read/write completion counters.
module line_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = line_mem_pkg::LINE_W,
  parameter int DEPTH   = line_mem_pkg::DEPTH_DEF,
  parameter int LATENCY = line_mem_pkg::LATENCY_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
`endif
);

  import line_mem_pkg::*;

  localparam int OFF_B = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic                wr_q;
  logic [IDX_W-1:0]    idx_q;
  logic [LINE_W-1:0]   wdata_q;

  logic [IDX_W-1:0]    addr_idx;
  logic                commit;
  logic                c_wr;
  logic [IDX_W-1:0]    c_idx;
  logic [LINE_W-1:0]   c_data;
  logic                mem_we;
  logic                mem_re;

  assign addr_idx = addr_i[OFF_B +: IDX_W];

  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_W-1:OFF_B+IDX_W], addr_i[OFF_B-1:0]};

  // With LATENCY == 1 the commit edge is the accepting edge, so the live
  // inputs feed the array; otherwise the captured request does.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    commit = 1'b0;
    c_wr   = wr_q;
    c_idx  = idx_q;
    c_data = wdata_q;
    if (state == IDLE) begin
      commit = enable_i && (LATENCY == 1);
      c_wr   = write_i;
      c_idx  = addr_idx;
      c_data = data_i;
    end else if (state == WAIT) begin
      commit = (cnt == '0);
    end
  end

  // A reset on the commit edge aborts the access entirely.
  assign mem_we = commit && c_wr && !rst_i;
  assign mem_re = commit && !c_wr && !rst_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      ack_o  <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable_i) begin
            wr_q    <= write_i;
            idx_q   <= addr_idx;
            wdata_q <= data_i;
            busy_o  <= 1'b1;
            if (LATENCY == 1) begin
              state <= ACK;
              ack_o <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= ACK;
            ack_o <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  line_mem_array #(
    .LINE_W_P (LINE_W),
    .DEPTH    (DEPTH)
  ) u_array (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (c_idx),
    .wdata (c_data),
    .rdata (data_o)
  );

`ifdef LINE_MEM_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      if (mem_re && rd_cnt_o != 32'hFFFF_FFFF) rd_cnt_o <= rd_cnt_o + 32'd1;
      if (mem_we && wr_cnt_o != 32'hFFFF_FFFF) wr_cnt_o <= wr_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomised self-checking bench for line_mem_responder (LATENCY 10 and 1).
// Define LINE_MEM_STATS_EN to also exercise the statistics counters.
module tb_line_mem_responder;

  localparam int LAT  = 10;
  localparam int NIDX = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         enable = 1'b0, write = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic         ack, busy;
  logic [255:0] rdata;

  logic         en1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [255:0] wdata1 = '0;
  logic         ack1, busy1;
  logic [255:0] rdata1;

`ifdef LINE_MEM_STATS_EN
  logic [31:0] rd_cnt, wr_cnt, rd_cnt1, wr_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: line contents by index, plus the last line read out.
  logic [255:0] model [int];
  logic [255:0] last_read;

  line_mem_responder #(.LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .write_i(write),
    .addr_i(addr), .data_i(wdata), .ack_o(ack), .data_o(rdata), .busy_o(busy)
`ifdef LINE_MEM_STATS_EN
    , .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
`endif
  );

  line_mem_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1),
    .addr_i(addr1), .data_i(wdata1), .ack_o(ack1), .data_o(rdata1), .busy_o(busy1)
`ifdef LINE_MEM_STATS_EN
    , .rd_cnt_o(rd_cnt1), .wr_cnt_o(wr_cnt1)
`endif
  );

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % NIDX);
  endfunction

  // Drives one request on dut from a negedge with dut idle. Reports the ack
  // cycle (1 = cycle after the accepting edge, -1 on timeout), the line seen in
  // the ack cycle, ack one cycle later, whether busy held up to ack, and busy
  // in the following cycle. Address/data are scrambled while waiting.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [255:0] d,
                       output int lat, output logic [255:0] rd, output logic ack_next,
                       output logic busy_ok, output logic busy_after);
    lat = -1; busy_ok = 1'b1; rd = '0;
    enable = 1'b1; write = wr; addr = a; wdata = d;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (ack === 1'b1) begin
        lat = k;
        rd  = rdata;
        break;
      end
      if (k == 2) begin
        addr  = $urandom;
        wdata = {8{$urandom}};
      end
    end
    enable = 1'b0;
    @(negedge clk);
    ack_next   = ack;
    busy_after = busy;
  endtask

  task automatic test_reset();
    int acks = 0;
    rst = 1'b1; enable = 1'b0; en1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rdata !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", rdata); end
    repeat (20) begin
      @(negedge clk);
      if (ack === 1'b1 || ack1 === 1'b1) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL idle_acks got=%0d want=0", acks); end
    last_read = '0;
  endtask

  task automatic test_write_read();
    int lat; logic [255:0] rd; logic an, bok, ba;
    logic [255:0] line = {8{32'hDEADBEEF}};
    issue(1'b1, 32'h0000_0040, line, lat, rd, an, bok, ba);
    total++; if (lat !== LAT) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", lat, LAT); end
    total++; if (an !== 1'b0) begin bad++; $display("FAIL wr_ack_width got=%b want=0", an); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b want=1", bok); end
    total++; if (ba !== 1'b0) begin bad++; $display("FAIL wr_busy_after got=%b want=0", ba); end
    total++; if (rd !== last_read) begin bad++; $display("FAIL wr_data_hold got=%h want=%h", rd, last_read); end
    model[line_of(32'h40)] = line;
    issue(1'b0, 32'h0000_0040, '0, lat, rd, an, bok, ba);
    total++; if (lat !== LAT) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", lat, LAT); end
    total++; if (rd !== line) begin bad++; $display("FAIL rd_data got=%h want=%h", rd, line); end
    total++; if (an !== 1'b0) begin bad++; $display("FAIL rd_ack_width got=%b want=0", an); end
    last_read = line;
  endtask

  task automatic test_alias();
    int lat; logic [255:0] rd; logic an, bok, ba;
    logic [255:0] line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    issue(1'b1, 32'h0000_0020, line, lat, rd, an, bok, ba);
    model[line_of(32'h20)] = line;
    issue(1'b0, 32'h0000_003C, '0, lat, rd, an, bok, ba);
    total++; if (rd !== model[line_of(32'h3C)]) begin bad++; $display("FAIL alias_offset got=%h want=%h", rd, line); end
    issue(1'b0, 32'h0000_4020, '0, lat, rd, an, bok, ba);
    total++; if (rd !== model[line_of(32'h4020)]) begin bad++; $display("FAIL alias_upper got=%h want=%h", rd, line); end
    last_read = line;
  endtask

  task automatic test_reset_mid();
    int lat; logic [255:0] rd; logic an, bok, ba;
    int acks = 0;
    logic [255:0] prior = {8{$urandom | 32'h100}};
    issue(1'b1, 32'h80, prior, lat, rd, an, bok, ba);
    model[line_of(32'h80)] = prior;
    enable = 1'b1; write = 1'b1; addr = 32'h80; wdata = 256'h1;
    repeat (4) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL abort_ack got=%0d want=0", acks); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (rdata !== '0) begin bad++; $display("FAIL abort_data got=%h want=0", rdata); end
    issue(1'b0, 32'h80, '0, lat, rd, an, bok, ba);
    total++; if (rd !== model[line_of(32'h80)]) begin bad++; $display("FAIL abort_keep got=%h want=%h", rd, prior); end
    last_read = prior;
  endtask

  task automatic test_lat1();
    logic [255:0] line = {8{$urandom}};
    logic exp_ack [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_0100; wdata1 = line;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (ack1 !== exp_ack[k-1] || busy1 !== exp_ack[k-1]) begin
        bad++;
        $display("FAIL lat1_cycle%0d got ack=%b busy=%b want=%b", k, ack1, busy1, exp_ack[k-1]);
      end
      if (k == 1) begin wr1 = 1'b0; wdata1 = ~line; end
      if (k == 3) begin
        total++; if (rdata1 !== line) begin bad++; $display("FAIL lat1_read got=%h want=%h", rdata1, line); end
        en1 = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [255:0] rd; logic an, bok, ba;
    int pool [4] = '{3, 7, 100, 511};
    for (int t = 0; t < 40; t++) begin
      int idx = pool[$urandom_range(0, 3)];
      logic [31:0] a = ($urandom & 32'hFFFF_C000) | (idx << 5) | $urandom_range(0, 31);
      logic wr = ($urandom_range(0, 1) == 1) || !model.exists(idx);
      logic [255:0] d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      issue(wr, a, d, lat, rd, an, bok, ba);
      total++; if (lat !== LAT || an !== 1'b0) begin bad++; $display("FAIL rand%0d_timing got lat=%0d next=%b want lat=%0d next=0", t, lat, an, LAT); end
      if (wr) begin
        model[idx] = d;
        total++; if (rd !== last_read) begin bad++; $display("FAIL rand%0d_hold got=%h want=%h", t, rd, last_read); end
      end else begin
        total++; if (rd !== model[idx]) begin bad++; $display("FAIL rand%0d_read got=%h want=%h", t, rd, model[idx]); end
        last_read = model[idx];
      end
    end
  endtask

`ifdef LINE_MEM_STATS_EN
  task automatic test_stats();
    int lat; logic [255:0] rd; logic an, bok, ba;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(i < 2, 32'h200 + 32'(i), {8{32'(i)}}, lat, rd, an, bok, ba);
    end
    total++; if (rd_cnt !== 32'd3) begin bad++; $display("FAIL stats_rd got=%0d want=3", rd_cnt); end
    total++; if (wr_cnt !== 32'd2) begin bad++; $display("FAIL stats_wr got=%0d want=2", wr_cnt); end
    force dut.rd_cnt_o = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.rd_cnt_o;
    issue(1'b0, 32'h200, '0, lat, rd, an, bok, ba);
    total++; if (rd_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stats_sat got=%h want=ffffffff", rd_cnt); end
    total++; if (wr_cnt !== 32'd2) begin bad++; $display("FAIL stats_wr_keep got=%0d want=2", wr_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_reset_mid();
    test_lat1();
    test_random();
`ifdef LINE_MEM_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Responder (slave) end of the dcache-to-memory line interface: enable/write/address/256-bit data in, ack/256-bit data out.
- Models a line-wide backing memory with a fixed, parameterised access latency.
- Serves as the memory-side counterpart for the data cache refill/write-back path, and as a reusable responder for a future instruction cache.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, line width in bits; byte offset bits OFF = log2(LINE_W/8) = 5.
- DEPTH, 512, number of lines, power of two; IDX_W = log2(DEPTH).
- LATENCY, 10, cycles from request acceptance to ack; legal range 1..255.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  request valid; held by initiator until ack seen.
- write_i  in  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  in  ADDR_W  byte address; line index = addr_i[OFF+IDX_W-1:OFF]; offset and upper bits ignored.
- data_i  in  LINE_W  write line; sampled at acceptance.
- ack_o  out  1  registered one-cycle completion pulse.
- data_o  out  LINE_W  registered read line, valid in the ack cycle, held afterwards.
- busy_o  out  1  high from acceptance until the ack cycle inclusive.

Behaviour:
- Reset: sync, active-high. state = IDLE, counter = 0, ack_o = 0, busy_o = 0, data_o = 0. Array contents are not cleared. Reset mid-request aborts it: no ack, and a pending write is discarded (array unchanged).
- States: IDLE, WAIT, ACK.
- IDLE: on an edge with enable_i = 1, capture write_i, index and data_i.
  - LATENCY = 1: go to ACK.
  - Otherwise: go to WAIT with counter = LATENCY - 2.
- WAIT: counter decrements each edge. At counter = 0, go to ACK. enable_i, addr_i and data_i are ignored (captured copies are used).
- Access on the edge entering ACK:
  - Write: array[idx] <= captured data.
  - Read: data_o <= array[idx].
  - ack_o <= 1.
- ACK: lasts one cycle, then IDLE unconditionally; ack_o returns to 0.
- Latency: ack_o is high in the cycle that begins exactly LATENCY edges after the accepting edge.
- Turnaround: enable_i still high in ACK is not a new request; acceptance happens only in IDLE. The initiator drops enable_i after sampling ack_o. Back-to-back requests cost one IDLE cycle minimum.
- data_o: changes only on read completion; writes leave it unchanged.
- busy_o = (state != IDLE).
- Index wrap: addresses differing only above bit OFF+IDX_W-1 alias to the same line.
- Read after write to the same line returns the written data (write committed before any later acceptance).

Optional Feature:
- Macro: LINE_MEM_STATS_EN.
- Defined: adds outputs rd_cnt_o[31:0] and wr_cnt_o[31:0].
  - Each increments on the edge entering ACK for a read or a write respectively.
  - Saturate at 32'hFFFFFFFF.
  - Reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package line_mem_pkg: LINE_W, OFF, default DEPTH/LATENCY constants, state enum {IDLE, WAIT, ACK}.
- Sub-module line_mem_array: single-port DEPTH x LINE_W storage with synchronous write and read at the commit edge. The FSM and latency counter stay in the top.

Test Plan:
- Reset then idle: rst_i = 1 for 2 cycles -> ack_o = 0, busy_o = 0, data_o = 0; no ack for 20 cycles with enable_i = 0.
- Write then read, LATENCY = 10: write addr 32'h0000_0040 with data {8{32'hDEADBEEF}}, holding enable until ack.
  - ack_o pulses in cycle 10 after acceptance, for exactly 1 cycle.
  - Read of 32'h0000_0040 acks 10 cycles after its acceptance with data_o = {8{32'hDEADBEEF}}.
- Offset/alias, DEPTH = 512: write line at 32'h0000_0020; read 32'h0000_003C and 32'h0000_4020 (index 1 both) -> both return the written line.
- Reset mid-request: accept write of 256'h1 at 32'h80; assert rst_i at cycle 5 -> no ack. A subsequent read of 32'h80 returns the prior contents, not 256'h1.
- LATENCY = 1: enable_i held high across two requests -> ack cycles 1 and 3 after the first acceptance; ACK-state enable is not accepted; busy_o low only in the IDLE cycle.
- LINE_MEM_STATS_EN: 3 reads + 2 writes -> rd_cnt_o = 3, wr_cnt_o = 2. Preload 32'hFFFFFFFF by force, do one more read -> rd_cnt_o stays 32'hFFFFFFFF.
